uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 35 +++
 rtl/uart_rx_cfg.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
//   rx_state_e       receiver FSM states
//   PAR_*            parity-mode encodings for the PARITY parameter
//   MAX_FRAME_BITS   longest frame: start + 9 data + parity + 2 stop
//   first_sample_pt  counter value at which the start bit is sampled
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int MAX_FRAME_BITS = 13;

    // Later bits sit a whole bit period further on from this point.
    function automatic int first_sample_pt(input int clk_per_bit);
        return clk_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receive line.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset (all flops preset to idle-high)
//   rxd_i   raw asynchronous serial line
//   sync_o  2-flop synchronised line
//   fall_o  1-to-0 transition of the synchronised line
//   maj_o   majority of the last 3 synchronised samples (ending with sync_o)
module uart_rx_sampler (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rxd_i,
    output logic sync_o,
    output logic fall_o,
    output logic maj_o
);

    logic [1:0] sync_q;
    logic [1:0] hist_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
            hist_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
            hist_q <= {hist_q[0], sync_q[1]};
        end
    end

    assign sync_o = sync_q[1];
    assign fall_o = hist_q[0] & ~sync_q[1];
    assign maj_o  = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with a one-deep output hold register.
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   rxd                  asynchronous serial line, idle high
//   rdata, rdata_valid   held frame and its valid flag
//   rdata_ack            consumer takes the held frame this cycle
//   ferr, perr, brk      stop-bit, parity and break flags of the held frame
//   overrun              a frame was dropped while rdata_valid was high
//   busy                 FSM not idle
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | waiting for a falling edge on the synchronised line
// ST_START    | checking the start bit at mid-bit, rejects glitches
// ST_DATA     | shifting DATA_BITS samples in, LSB first
// ST_PARITY   | sampling and checking the parity bit
// ST_STOP     | sampling STOP_BITS stop bits, frame completes on last
// ST_BRK_WAIT | break received, waiting for the line to return high
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 rdata_valid,
    input  logic                 rdata_ack,
    output logic                 ferr,
    output logic                 perr,
    output logic                 brk,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(MAX_FRAME_BITS * CLK_PER_BIT + 1);

    logic rx_sync, rx_fall, rx_maj;

    uart_rx_sampler u_sampler (
        .clk_i  (clk),
        .rst_i  (rst),
        .rxd_i  (rxd),
        .sync_o (rx_sync),
        .fall_o (rx_fall),
        .maj_o  (rx_maj)
    );

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     pt_q, pt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 zero_q, zero_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 brk_q, brk_d;
    logic                 ovr_q, ovr_d;
    logic                 sample;
    logic                 done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pt_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            zero_q  <= 1'b0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pt_q    <= pt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            zero_q  <= zero_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            brk_q   <= brk_d;
            ovr_q   <= ovr_d;
        end
    end

    // pt_q tracks the next sample point so no multiply is needed per bit.
    assign sample = (cnt_q == pt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pt_d    = pt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        zero_d  = zero_q;
        rdata_d = rdata_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        brk_d   = brk_q;
        ovr_d   = ovr_q;
        done    = 1'b0;

        if (state_q != ST_IDLE && state_q != ST_BRK_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (sample) pt_d = pt_q + CNT_W'(CLK_PER_BIT);
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_fall) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    pt_d    = CNT_W'(first_sample_pt(CLK_PER_BIT));
                end
            end
            ST_START: begin
                if (sample) begin
                    if (rx_maj) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                        par_d   = 1'b0;
                        fe_d    = 1'b0;
                        pe_d    = 1'b0;
                        zero_d  = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shift_d = {rx_maj, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ rx_maj;
                    zero_d  = zero_q & ~rx_maj;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample) begin
                    // Even: error when data^parity is 1; odd: error when it is 0.
                    pe_d    = (PARITY == PAR_ODD) ? ~(par_q ^ rx_maj) : (par_q ^ rx_maj);
                    zero_d  = zero_q & ~rx_maj;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    fe_d   = fe_q | ~rx_maj;
                    zero_d = zero_q & ~rx_maj;
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        done    = 1'b1;
                        state_d = zero_d ? ST_BRK_WAIT : ST_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_BRK_WAIT: begin
                if (rx_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            if (!valid_q || rdata_ack) begin
                rdata_d = shift_q;
                ferr_d  = fe_d;
                perr_d  = pe_q;
                brk_d   = zero_d;
                valid_d = 1'b1;
                ovr_d   = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rdata_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = valid_q;
    assign ferr        = ferr_q;
    assign perr        = perr_q;
    assign brk         = brk_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) at 16 clocks/bit,
// each checked every cycle against a frame-level model of the output hold.
module tb_uart_rx_cfg;

    localparam int CPB     = 16;
    localparam int HALF_PT = CPB / 2 - 1;

    typedef struct {
        int unsigned done_cyc;
        logic [7:0]  data;
        logic        ferr;
        logic        perr;
        logic        brk;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd   [3];
    logic       ack   [3];
    logic [7:0] rdata [3];
    logic       valid [3];
    logic       ferr  [3];
    logic       perr  [3];
    logic       brk   [3];
    logic       ovr   [3];
    logic       busy  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_rx_cfg #(
            .CLK_PER_BIT (CPB),
            .DATA_BITS   (8),
            .PARITY      ((g == 1) ? 1 : 0),
            .STOP_BITS   ((g == 2) ? 2 : 1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .rxd         (rxd[g]),
            .rdata       (rdata[g]),
            .rdata_valid (valid[g]),
            .rdata_ack   (ack[g]),
            .ferr        (ferr[g]),
            .perr        (perr[g]),
            .brk         (brk[g]),
            .overrun     (ovr[g]),
            .busy        (busy[g])
        );
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    frame_t      exp_q [3][$];
    logic        m_valid [3];
    logic [7:0]  m_data  [3];
    logic        m_ferr  [3];
    logic        m_perr  [3];
    logic        m_brk   [3];
    logic        m_ovr   [3];
    logic        prev_valid [3];
    int unsigned rise_cyc   [3];
    int unsigned last_fall  [3];

    function automatic int npar(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int nstop(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    task automatic check(input string nm, input int inst, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %0h, expected %0h", nm, inst, cyc, act, exp);
        end
    endtask

    // Output-hold model: a frame becomes visible at its completion cycle;
    // ack consumes, an un-acked completion while full is dropped.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_valid[i] = 1'b0; m_data[i] = '0; m_ferr[i] = 1'b0;
                m_perr[i]  = 1'b0; m_brk[i]  = 1'b0; m_ovr[i] = 1'b0;
                exp_q[i].delete();
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (exp_q[i].size() > 0 && exp_q[i][0].done_cyc == cyc) begin
                    frame_t f;
                    f = exp_q[i].pop_front();
                    if (!m_valid[i] || ack[i]) begin
                        m_valid[i] = 1'b1; m_data[i] = f.data; m_ferr[i] = f.ferr;
                        m_perr[i]  = f.perr; m_brk[i] = f.brk; m_ovr[i]  = 1'b0;
                    end else begin
                        m_ovr[i] = 1'b1;
                    end
                end else if (ack[i] && m_valid[i]) begin
                    m_valid[i] = 1'b0;
                    m_ovr[i]   = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                check("valid", i, 9'(valid[i]), 9'(m_valid[i]));
                check("overrun", i, 9'(ovr[i]), 9'(m_ovr[i]));
                if (m_valid[i]) begin
                    check("rdata", i, 9'(rdata[i]), 9'(m_data[i]));
                    check("ferr", i, 9'(ferr[i]), 9'(m_ferr[i]));
                    check("perr", i, 9'(perr[i]), 9'(m_perr[i]));
                    check("brk", i, 9'(brk[i]), 9'(m_brk[i]));
                end
                if (valid[i] && !prev_valid[i]) rise_cyc[i] = cyc;
                prev_valid[i] = valid[i];
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; stops[s] is the level of stop bit s.
    task automatic send_frame(input int i, input logic [7:0] d, input bit bad_par, input logic [1:0] stops);
        logic   bits [$];
        logic   pb;
        frame_t f;
        logic   all_stop_zero;
        pb = (^d) ^ (npar(i) == 2);
        if (bad_par) pb = ~pb;
        bits.push_back(1'b0);
        for (int j = 0; j < 8; j++) bits.push_back(d[j]);
        if (npar(i) != 0) bits.push_back(pb);
        for (int s = 0; s < nstop(i); s++) bits.push_back(stops[s]);
        all_stop_zero = !stops[0] && (nstop(i) == 1 || !stops[1]);
        f.data = d;
        f.ferr = !stops[0] || (nstop(i) == 2 && !stops[1]);
        f.perr = (npar(i) == 1) ? ((^d) ^ pb) : (npar(i) == 2) ? ~((^d) ^ pb) : 1'b0;
        f.brk  = (d == 8'h00) && (npar(i) == 0 || !pb) && all_stop_zero;
        @(negedge clk);
        last_fall[i] = cyc;
        // 2 synchroniser flops + 1 edge cycle + 1 register stage after the final sample.
        f.done_cyc = cyc + 4 + HALF_PT + (bits.size() - 1) * CPB;
        exp_q[i].push_back(f);
        foreach (bits[b]) begin
            rxd[i] = bits[b];
            wait_cyc(CPB);
        end
        rxd[i] = 1'b1;
    endtask

    task automatic do_ack(input int i);
        @(negedge clk);
        ack[i] = 1'b1;
        @(negedge clk);
        ack[i] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rxd[i] = 1'b1; ack[i] = 1'b0; prev_valid[i] = 1'b0;
            rise_cyc[i] = 0; last_fall[i] = 0;
        end
        rst = 1'b1;
        wait_cyc(5);
        for (int i = 0; i < 3; i++) begin
            check("rst_rdata", i, 9'(rdata[i]), 9'h000);
            check("rst_valid", i, 9'(valid[i]), 9'h000);
            check("rst_busy", i, 9'(busy[i]), 9'h000);
            check("rst_ovr", i, 9'(ovr[i]), 9'h000);
        end
        rst = 1'b0;
        wait_cyc(10);

        // 8N1 0x5A: latency from start edge to rdata_valid is 4 + 7 + 9*16 = 155.
        send_frame(0, 8'h5A, 1'b0, 2'b11);
        wait_cyc(4);
        check("n1_rdata", 0, 9'(rdata[0]), 9'h05A);
        check("n1_flags", 0, {6'd0, ferr[0], perr[0], brk[0]}, 9'h000);
        check("n1_lat", 0, 9'(rise_cyc[0] - last_fall[0]), 9'd155);
        check("n1_busy", 0, 9'(busy[0]), 9'h000);
        do_ack(0);
        wait_cyc(2);
        check("n1_ack", 0, 9'(valid[0]), 9'h000);

        // 8E1: 0x5A has even weight, correct parity 0, so 1 is wrong.
        send_frame(1, 8'h5A, 1'b1, 2'b11);
        wait_cyc(4);
        check("e1_rdata", 1, 9'(rdata[1]), 9'h05A);
        check("e1_perr", 1, 9'(perr[1]), 9'h001);
        do_ack(1);
        send_frame(1, 8'hA5, 1'b0, 2'b11);
        wait_cyc(4);
        check("e1_rdata2", 1, 9'(rdata[1]), 9'h0A5);
        check("e1_perr2", 1, 9'(perr[1]), 9'h000);
        do_ack(1);

        // 8N2: second stop bit low.
        send_frame(2, 8'hC3, 1'b0, 2'b01);
        wait_cyc(4);
        check("n2_ferr", 2, 9'(ferr[2]), 9'h001);
        check("n2_rdata", 2, 9'(rdata[2]), 9'h0C3);
        do_ack(2);
        wait_cyc(5);

        // Break: 12 bit times low on the 8N2 instance (11-bit frame).
        begin
            frame_t f;
            @(negedge clk);
            f.done_cyc = cyc + 4 + HALF_PT + 10 * CPB;
            f.data = 8'h00; f.ferr = 1'b1; f.perr = 1'b0; f.brk = 1'b1;
            exp_q[2].push_back(f);
            rxd[2] = 1'b0;
            wait_cyc(12 * CPB);
            check("brk_busy", 2, 9'(busy[2]), 9'h001);
            check("brk_flag", 2, 9'(brk[2]), 9'h001);
            check("brk_ferr", 2, 9'(ferr[2]), 9'h001);
            check("brk_rdata", 2, 9'(rdata[2]), 9'h000);
            rxd[2] = 1'b1;
            wait_cyc(8);
            check("brk_idle", 2, 9'(busy[2]), 9'h000);
            do_ack(2);
        end

        // Back-to-back frames without ack.
        send_frame(0, 8'h11, 1'b0, 2'b11);
        send_frame(0, 8'h22, 1'b0, 2'b11);
        wait_cyc(4);
        check("ovr_rdata", 0, 9'(rdata[0]), 9'h011);
        check("ovr_flag", 0, 9'(ovr[0]), 9'h001);
        do_ack(0);
        wait_cyc(2);
        check("ovr_clr_v", 0, 9'(valid[0]), 9'h000);
        check("ovr_clr_o", 0, 9'(ovr[0]), 9'h000);

        // One-clock glitch on idle line.
        @(negedge clk);
        rxd[0] = 1'b0;
        @(negedge clk);
        rxd[0] = 1'b1;
        wait_cyc(CPB + 6);
        check("glitch_busy", 0, 9'(busy[0]), 9'h000);
        check("glitch_valid", 0, 9'(valid[0]), 9'h000);

        // Reset in the middle of data bit 3, then a clean frame.
        begin
            logic [7:0] d;
            d = 8'h96;
            @(negedge clk);
            rxd[0] = 1'b0;
            wait_cyc(CPB);
            for (int j = 0; j < 3; j++) begin
                rxd[0] = d[j];
                wait_cyc(CPB);
            end
            rxd[0] = d[3];
            wait_cyc(CPB / 2);
            rst = 1'b1;
            rxd[0] = 1'b1;
            wait_cyc(3);
            rst = 1'b0;
            wait_cyc(30 * CPB);
            check("abort_valid", 0, 9'(valid[0]), 9'h000);
            check("abort_busy", 0, 9'(busy[0]), 9'h000);
        end
        send_frame(0, 8'h3C, 1'b0, 2'b11);
        wait_cyc(4);
        check("after_rst", 0, 9'(rdata[0]), 9'h03C);
        do_ack(0);

        // Randomised traffic across all three formats.
        for (int n = 0; n < 36; n++) begin
            int         i;
            logic [7:0] d;
            bit         bp;
            logic [1:0] st;
            i  = $urandom_range(0, 2);
            d  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            bp = (i == 1) && ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            send_frame(i, d, bp, st);
            wait_cyc($urandom_range(2, 30));
            if ($urandom_range(0, 2) != 0) do_ack(i);
            wait_cyc($urandom_range(2, 20));
        end

        wait_cyc(50);
        for (int i = 0; i < 3; i++) check("queue_empty", i, 9'(exp_q[i].size()), 9'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
